fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned DEFAULT_N = 32;
  localparam int unsigned DEFAULT_R = 7;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO holding {instr, pc} pairs, with a single-cycle flush.
module fetch_queue #(
  parameter int unsigned W     = 39,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign rdata_o = mem_q[rptr_q];

  // A push into a full queue is legal only when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register driving imem, fetch queue toward decode, redirect flush.
// Optional halt-on-HALT_INSTR behaviour is enabled by defining FETCH_HALT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned N        = DEFAULT_N,
  parameter int unsigned R        = DEFAULT_R,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [R-1:0] readAddr,
  input  logic [N-1:0] instr,
  input  logic         redirect_valid,
  input  logic [R-1:0] redirect_addr,
  output logic         out_valid,
  output logic [N-1:0] out_instr,
  output logic [R-1:0] out_pc,
  input  logic         out_ready,
  output logic         halted
);

  localparam int unsigned W = N + R;

  fetch_state_e state_q;
  logic [R-1:0] pc_q;
  logic         halted_q;
  logic         q_empty, q_full;
  logic         push, pop, halt_hit;
  logic [W-1:0] q_rdata;

  assign readAddr  = pc_q;
  assign out_valid = !q_empty;
  assign out_instr = q_rdata[W-1:R];
  assign out_pc    = q_rdata[R-1:0];
  assign halted    = halted_q;

  assign pop  = out_valid && out_ready;
  assign push = (state_q == RUN) && !redirect_valid && (!q_full || pop);

`ifdef FETCH_HALT_EN
  assign halt_hit = (instr == N'(HALT_INSTR));
`else
  assign halt_hit = 1'b0;
`endif

  fetch_queue #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({instr, pc_q}),
    .pop_i   (pop),
    .rdata_o (q_rdata),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= R'(RESET_PC);
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_addr;
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else if (push) begin
      // The halt word itself is enqueued; PC stays pointing at it.
      if (halt_hit) begin
        state_q  <= HALT;
        halted_q <= 1'b1;
      end else begin
        pc_q <= pc_q + R'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a queue-level model.
module tb_fetch_unit;

  localparam int unsigned N     = 32;
  localparam int unsigned R     = 7;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [N-1:0] instr;
    logic [R-1:0] pc;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [R-1:0] readAddr;
  logic [N-1:0] instr;
  logic         redirect_valid;
  logic [R-1:0] redirect_addr;
  logic         out_valid;
  logic [N-1:0] out_instr;
  logic [R-1:0] out_pc;
  logic         out_ready;
  logic         halted;

  logic [N-1:0] imem [128];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected queue contents, fetch PC and halt flag.
  ent_t         exp_q [$];
  logic [R-1:0] mdl_pc;
  logic         mdl_halted;
  bit           mdl_init = 0;

  always #5 clk = ~clk;

  assign instr = imem[readAddr];

  fetch_unit #(
    .N        (N),
    .R        (R),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .readAddr       (readAddr),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .halted         (halted)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Model update on every edge, from the inputs as they stand at that edge.
  always @(posedge clk) begin
    logic [N-1:0] word;
    bit           do_pop, do_push;
    if (reset) begin
      exp_q.delete();
      mdl_pc     = '0;
      mdl_halted = 1'b0;
      mdl_init   = 1;
    end else if (mdl_init) begin
      if (redirect_valid) begin
        exp_q.delete();
        mdl_pc     = redirect_addr;
        mdl_halted = 1'b0;
      end else begin
        word    = imem[mdl_pc];
        do_pop  = (exp_q.size() != 0) && out_ready;
        do_push = !mdl_halted && ((exp_q.size() < DEPTH) || do_pop);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          exp_q.push_back('{instr: word, pc: mdl_pc});
`ifdef FETCH_HALT_EN
          if (word == 32'hFFFF_FFFF) mdl_halted = 1'b1;
          else mdl_pc = mdl_pc + 7'd1;
`else
          mdl_pc = mdl_pc + 7'd1;
`endif
        end
      end
    end
  end

  // Monitor: compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (mdl_init) begin
      check("readAddr", 64'(readAddr), 64'(mdl_pc));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("halted", 64'(halted), 64'(mdl_halted));
      if (out_valid && exp_q.size() != 0) begin
        check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'(i + 1);
`ifdef FETCH_HALT_EN
    imem[3] = 32'hFFFF_FFFF;
`endif
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    out_ready      = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_readAddr", 64'(readAddr), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);

    // Streaming with decode always ready.
    out_ready = 1'b1;
    step();
    check("first_out_valid", 64'(out_valid), 64'h1);
    check("first_out_pc", 64'(out_pc), 64'h0);
    for (int i = 0; i < 9; i++) step();

    // Backpressure fills the queue, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Redirect with a full queue.
    out_ready = 1'b0;
    step();
    step();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 7'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_out_valid", 64'(out_valid), 64'h0);
    check("redir_readAddr", 64'(readAddr), 64'h40);
    step();
    check("redir_out_pc", 64'(out_pc), 64'h40);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_addr  = 7'h7E;
    step();
    redirect_valid = 1'b0;
    check("wrap_0", 64'(readAddr), 64'h7E);
    step();
    check("wrap_1", 64'(readAddr), 64'h7F);
    step();
    check("wrap_2", 64'(readAddr), 64'h00);
    step();
    check("wrap_3", 64'(readAddr), 64'h01);

    // Reset during a stall with a full queue.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("stall_rst_out_valid", 64'(out_valid), 64'h0);
    check("stall_rst_readAddr", 64'(readAddr), 64'h0);

    // Random traffic with scattered halt words.
    for (int i = 0; i < 128; i++) begin
      imem[i] = $urandom;
      if ($urandom_range(0, 15) == 0) imem[i] = 32'hFFFF_FFFF;
    end
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 199) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0) || (mdl_halted && $urandom_range(0, 3) == 0);
      redirect_addr  = 7'($urandom_range(0, 127));
      step();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
